data_mem_responder: RTL

Multi-cycle data-memory responder on the far end of the control unit's `memRead`/`memWrite` strobes. It accepts a load or store request from the datapath and holds `stall` high while the access is in flight. It performs byte, half or word accesses on an internal word-organised array, then returns load data with a one-cycle `ready` pulse. It replaces the zero-latency data memory so that the core can model real memory wait states.

---
 rtl/data_mem_responder.sv | 109 ++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle byte/half/word data memory that stalls the core while an access is in flight
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   memRead, memWrite   load/store strobes (both high = store)
//   funct3              access size and sign (instr[14:12])
//   addr, wdata         byte address and store data
//   rdata, misaligned   load result and fault flag, valid while ready
//   ready               one-cycle completion pulse
//   stall               high while a request waits or is in flight
// Optional macro DMEM_ALIGN_CHECK_EN: flag and suppress misaligned accesses instead of force-aligning them.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        stall,
    output logic        misaligned
);
    localparam int AW = $clog2(DEPTH_WORDS);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, next;
    logic [3:0] cnt;
    logic [AW+1:0] a_q, a;
    logic [31:0] wd_q, d, old, mask, val, ld;
    logic [2:0] f_q, f;
    logic [1:0] lo;
    logic [7:0] b;
    logic [15:0] h;
    logic wr_q, wr, req, go, half, word, bad;
    logic unused_addr;
    logic [31:0] mem [DEPTH_WORDS];
    assign unused_addr = ^addr[31:AW+2];
    assign req = memRead | memWrite;
    always_comb begin
        next = state == IDLE ? (req ? (WAIT_CYCLES > 0 ? WAIT : RESP) : IDLE)
             : state == WAIT ? (cnt == 4'd0 ? RESP : WAIT) : IDLE;
        stall = (state == IDLE && req) || state == WAIT;
        ready = state == RESP;
        // the commit edge may be the accepting edge itself when there are no wait states,
        // so the access uses live inputs in IDLE and latched ones afterwards
        go = next == RESP && state != RESP;
        a = state == IDLE ? addr[AW+1:0] : a_q;
        f = state == IDLE ? funct3 : f_q;
        d = state == IDLE ? wdata : wd_q;
        wr = state == IDLE ? memWrite : wr_q;
        half = f[1:0] == 2'b01 && !(wr && f[2]);
        word = f == 3'b010;
`ifdef DMEM_ALIGN_CHECK_EN
        bad = (half && a[0]) || (word && a[1:0] != 2'b00);
        lo = a[1:0];
`else
        bad = 1'b0;
        lo = a[1:0] & ~{word, half | word};
`endif
        old = mem[a[AW+1:2]];
        b = old[{lo, 3'b000} +: 8];
        h = lo[1] ? old[31:16] : old[15:0];
        ld = f == 3'b000 ? {{24{b[7]}}, b}
           : f == 3'b001 ? {{16{h[15]}}, h}
           : f == 3'b010 ? old
           : f == 3'b100 ? {24'd0, b}
           : f == 3'b101 ? {16'd0, h} : 32'd0;
        mask = f == 3'b000 ? 32'h0000_00FF << {lo, 3'b000}
             : f == 3'b001 ? 32'h0000_FFFF << {lo, 3'b000}
             : f == 3'b010 ? 32'hFFFF_FFFF : 32'd0;
        val = f == 3'b000 ? {4{d[7:0]}} : f == 3'b001 ? {2{d[15:0]}} : d;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt <= 4'd0;
            a_q <= '0;
            wd_q <= 32'd0;
            f_q <= 3'd0;
            wr_q <= 1'b0;
            rdata <= 32'd0;
        end else begin
            state <= next;
            if (state == IDLE && req) begin
                a_q <= addr[AW+1:0];
                wd_q <= wdata;
                f_q <= funct3;
                wr_q <= memWrite;
            end
            if (state == IDLE && next == WAIT) cnt <= 4'(WAIT_CYCLES - 1);
            else if (cnt != 4'd0) cnt <= cnt - 4'd1;
            if (go) rdata <= (wr || bad) ? 32'd0 : ld;
        end
    end
`ifdef DMEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) misaligned <= 1'b0;
        else if (go) misaligned <= bad;
    end
`else
    assign misaligned = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst && go && wr && !bad) mem[a[AW+1:2]] <= (old & ~mask) | (val & mask);
    end
endmodule
